fetch_resp_queue: RTL and testbench
===================================

FETCH_RESP_QUEUE -- requirements
Module: fetch_resp_queue

Interface
REQ-001 SHALL have parameters: LANES, default 2, instructions per fetch response; INST_W, default 32, instruction width; PC_W, default 32, PC width; DEPTH, default 4, response-queue entries (power of 2, >=2); MAX_OUT, default 4, maximum in-flight instruction-RAM requests.
REQ-002 SHALL have ports, one per line:
 clk  input  1  sole clock; all state on rising edge
 rst_n  input  1  synchronous reset, active-high (1 = reset)
 req_fire_i  input  1  instruction-RAM request accepted this cycle
 req_pc_i  input  PC_W  PC of accepted request
 req_allowin_o  output  1  a new request may be issued
 data_ok_i  input  1  instruction-RAM response valid
 rdata_i  input  LANES*INST_W  response data, lane 0 in LSBs
 flush_i  input  1  exception or branch flush
 next_allowin_i  input  1  ID stage accepts this cycle
 out_valid_o  output  LANES  per-lane valid to ID
 out_inst_o  output  LANES*INST_W  instructions to ID
 out_pc_o  output  PC_W  PC of lane 0 (lane k = out_pc_o + 4k)
 err_o  output  1  sticky protocol error

Function
REQ-003 SHALL keep a pending-PC FIFO (MAX_OUT entries) of live requests: push req_pc_i on req_fire_i, pop on each non-discarded data_ok_i.
REQ-004 SHALL keep discard_cnt (width clog2(MAX_OUT+1)) counting stale in-flight requests; data_ok_i with discard_cnt>0 decrements it and drops the data, no FIFO or queue change.
REQ-005 SHALL push {popped PC, rdata_i, lane mask} into the response queue on a non-discarded data_ok_i; lane k valid iff PC word index mod LANES <= k.
REQ-006 SHALL drive out_valid_o = head lane mask when queue non-empty, else 0; out_inst_o/out_pc_o from head entry.
REQ-007 SHALL pop the head when any out_valid_o bit is 1 and next_allowin_i=1; simultaneous push and pop SHALL keep count unchanged, with pointers wrapping mod DEPTH.
REQ-008 SHALL assert req_allowin_o iff (live_cnt + q_count) < DEPTH and (live_cnt + discard_cnt) < MAX_OUT, guaranteeing every live response has a queue slot.
REQ-009 On flush_i: queue SHALL empty; pending FIFO SHALL clear; discard_cnt SHALL become live_cnt + discard_cnt - (data_ok_i ? 1 : 0); out_valid_o SHALL be 0 next cycle.
REQ-010 A data_ok_i in the flush_i cycle SHALL be dropped; a req_fire_i in the flush_i cycle SHALL belong to the new stream and be pushed to the emptied pending FIFO.
REQ-011 data_ok_i with discard_cnt=0 and pending FIFO empty SHALL be dropped and set err_o until reset.
REQ-012 req_fire_i while req_allowin_o=0 SHALL be ignored and set err_o.
REQ-013 Latency data_ok_i to out_valid_o: one cycle (registered queue), unless REQ-017 applies.

Reset
REQ-014 While rst_n=1 at a rising edge: queue, pending FIFO, discard_cnt, err_o SHALL clear; out_valid_o=0, err_o=0, req_allowin_o=1 the following cycle.
REQ-015 Reset SHALL override flush_i, req_fire_i, data_ok_i in the same cycle; in-flight responses arriving after reset are the environment's responsibility.
REQ-016 out_inst_o/out_pc_o SHALL be don't-care while out_valid_o=0.

Configuration
REQ-017 Macro FETCH_RESP_BYPASS_EN: when defined, a non-discarded data_ok_i with queue empty and no flush_i SHALL drive out_valid_o/out_inst_o/out_pc_o combinationally in the same cycle, and SHALL not be enqueued if next_allowin_i=1; when undefined, all responses pass through the queue (REQ-013).

Verification
REQ-018 Fire PC 0x1000 then 0x1008, two data_ok_i, next_allowin_i=1 -> out_valid_o=2'b11 with pc 0x1000 then 0x1008, one cycle after each response.
REQ-019 Fire PC 0x1004 -> response gives out_valid_o=2'b10, out_pc_o=0x1000 alignment base, lane1 = rdata_i[63:32].
REQ-020 Fire 3 requests, flush_i before any response, then 3 data_ok_i -> no out_valid_o, discard_cnt 3->0, err_o=0; new request afterwards delivered normally.
REQ-021 next_allowin_i=0, fire 4 requests and deliver 4 responses -> req_allowin_o=0 after 4th fire; queue full; no data lost; drains in order after next_allowin_i=1.
REQ-022 flush_i coincident with data_ok_i and req_fire_i (2 live) -> that response dropped, discard_cnt=1, new request live and delivered after stale one dropped.
REQ-023 data_ok_i with nothing outstanding -> err_o=1 and held until rst_n=1.

Source files
------------

// File: rtl/fetch_resp_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_resp_queue
// Purpose  : Tracks in-flight instruction-RAM fetches, drops stale responses
//            after a flush, and queues aligned multi-lane bundles for ID.
// Option   : FETCH_RESP_BYPASS_EN - same-cycle bypass when the queue is empty
// Revision : 1.0 - initial release
// ============================================================================
module fetch_resp_queue #(
  parameter int LANES   = 2,
  parameter int INST_W  = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_fire_i,
  input  logic [PC_W-1:0]         req_pc_i,
  output logic                    req_allowin_o,
  input  logic                    data_ok_i,
  input  logic [LANES*INST_W-1:0] rdata_i,
  input  logic                    flush_i,
  input  logic                    next_allowin_i,
  output logic [LANES-1:0]        out_valid_o,
  output logic [LANES*INST_W-1:0] out_inst_o,
  output logic [PC_W-1:0]         out_pc_o,
  output logic                    err_o
);

  localparam int c_data_w = LANES * INST_W;
  localparam int c_qptr_w = $clog2(DEPTH);
  localparam int c_qcnt_w = $clog2(DEPTH + 1);
  localparam int c_pptr_w = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int c_ocnt_w = $clog2(MAX_OUT + 1);
  localparam int c_sum_w  = ((c_qcnt_w > c_ocnt_w) ? c_qcnt_w : c_ocnt_w) + 1;
  localparam logic [c_pptr_w-1:0] c_pptr_last = c_pptr_w'(MAX_OUT - 1);

  // Pending-PC FIFO of live requests (MAX_OUT need not be a power of 2)
  logic [PC_W-1:0]     r_pend_pc [MAX_OUT];
  logic [c_pptr_w-1:0] r_pend_rd;
  logic [c_pptr_w-1:0] r_pend_wr;
  logic [c_ocnt_w-1:0] r_live_cnt;
  logic [c_ocnt_w-1:0] r_discard;

  // Response queue
  logic [PC_W-1:0]     r_q_pc   [DEPTH];
  logic [c_data_w-1:0] r_q_data [DEPTH];
  logic [LANES-1:0]    r_q_mask [DEPTH];
  logic [c_qptr_w-1:0] r_q_rd;
  logic [c_qptr_w-1:0] r_q_wr;
  logic [c_qcnt_w-1:0] r_q_cnt;
  logic                r_err;

  function automatic logic [c_pptr_w-1:0] f_pnext(input logic [c_pptr_w-1:0] p);
    return (p == c_pptr_last) ? '0 : p + c_pptr_w'(1);
  endfunction

  // Alignment of the oldest live request: lane base and valid-lane mask
  logic [PC_W-1:0]  w_pend_head;
  logic [PC_W-1:0]  w_word;
  logic [PC_W-1:0]  w_widx;
  logic [PC_W-1:0]  w_new_base;
  logic [LANES-1:0] w_new_mask;

  assign w_pend_head = r_pend_pc[r_pend_rd];
  assign w_word      = w_pend_head >> 2;
  assign w_widx      = w_word % PC_W'(LANES);
  assign w_new_base  = (w_word - w_widx) << 2;

  for (genvar k = 0; k < LANES; k++) begin : g_mask
    assign w_new_mask[k] = (w_widx <= PC_W'(k));
  end

  // Issue control: every live request must own a future queue slot
  logic [c_sum_w-1:0] w_out_sum;
  logic [c_sum_w-1:0] w_slot_sum;
  logic [c_sum_w-1:0] w_flush_disc;
  logic               w_allow;
  logic               w_fire_ok;
  logic               w_fire_bad;
  logic               w_disc_hit;
  logic               w_live_hit;
  logic               w_orphan;
  logic               w_accept;
  logic               w_dok_any;

  assign w_out_sum  = c_sum_w'(r_live_cnt) + c_sum_w'(r_discard);
  assign w_slot_sum = c_sum_w'(r_live_cnt) + c_sum_w'(r_q_cnt);
  assign w_allow    = (w_slot_sum < c_sum_w'(DEPTH)) && (w_out_sum < c_sum_w'(MAX_OUT));

  assign w_fire_ok  = req_fire_i && w_allow;
  assign w_fire_bad = req_fire_i && !w_allow;
  assign w_disc_hit = data_ok_i && (r_discard != '0);
  assign w_live_hit = data_ok_i && (r_discard == '0) && (r_live_cnt != '0);
  assign w_orphan   = data_ok_i && (w_out_sum == '0);
  assign w_accept   = w_live_hit && !flush_i;

  // On flush everything still outstanding becomes stale, minus a response landing now
  assign w_dok_any    = data_ok_i && (w_out_sum != '0);
  assign w_flush_disc = w_out_sum - c_sum_w'(w_dok_any);

  logic             w_q_empty;
  logic [LANES-1:0] w_head_mask;
  logic             w_q_push;
  logic             w_q_pop;

  assign w_q_empty   = (r_q_cnt == '0);
  assign w_head_mask = w_q_empty ? '0 : r_q_mask[r_q_rd];
  assign w_q_pop     = (|w_head_mask) && next_allowin_i;

`ifdef FETCH_RESP_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_accept && w_q_empty;
  assign out_valid_o = w_bypass ? w_new_mask : w_head_mask;
  assign out_inst_o  = w_bypass ? rdata_i    : r_q_data[r_q_rd];
  assign out_pc_o    = w_bypass ? w_new_base : r_q_pc[r_q_rd];
  assign w_q_push    = w_accept && !(w_bypass && next_allowin_i);
`else
  assign out_valid_o = w_head_mask;
  assign out_inst_o  = r_q_data[r_q_rd];
  assign out_pc_o    = r_q_pc[r_q_rd];
  assign w_q_push    = w_accept;
`endif

  assign req_allowin_o = w_allow;
  assign err_o         = r_err;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_pend_rd  <= '0;
      r_pend_wr  <= '0;
      r_live_cnt <= '0;
      r_discard  <= '0;
      r_q_rd     <= '0;
      r_q_wr     <= '0;
      r_q_cnt    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= r_err | w_fire_bad | w_orphan;
      if (flush_i) begin
        r_q_rd     <= '0;
        r_q_wr     <= '0;
        r_q_cnt    <= '0;
        r_pend_rd  <= '0;
        r_pend_wr  <= w_fire_ok ? f_pnext('0) : '0;
        r_live_cnt <= c_ocnt_w'(w_fire_ok);
        r_discard  <= c_ocnt_w'(w_flush_disc);
      end else begin
        if (w_q_push) begin
          r_q_wr <= r_q_wr + c_qptr_w'(1);
        end
        if (w_q_pop) begin
          r_q_rd <= r_q_rd + c_qptr_w'(1);
        end
        r_q_cnt <= r_q_cnt + c_qcnt_w'(w_q_push) - c_qcnt_w'(w_q_pop);
        if (w_fire_ok) begin
          r_pend_wr <= f_pnext(r_pend_wr);
        end
        if (w_live_hit) begin
          r_pend_rd <= f_pnext(r_pend_rd);
        end
        r_live_cnt <= r_live_cnt + c_ocnt_w'(w_fire_ok) - c_ocnt_w'(w_live_hit);
        if (w_disc_hit) begin
          r_discard <= r_discard - c_ocnt_w'(1);
        end
      end
    end
  end

  // Storage needs no reset; validity is carried by the pointers and counts
  logic [c_pptr_w-1:0] w_pend_widx;
  assign w_pend_widx = flush_i ? '0 : r_pend_wr;

  always_ff @(posedge clk) begin
    if (w_fire_ok) begin
      r_pend_pc[w_pend_widx] <= req_pc_i;
    end
    if (w_q_push) begin
      r_q_pc[r_q_wr]   <= w_new_base;
      r_q_data[r_q_wr] <= rdata_i;
      r_q_mask[r_q_wr] <= w_new_mask;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_resp_queue.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for fetch_resp_queue: vector table plus scoreboarded corner sequences.
module tb_fetch_resp_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_fire_i = 1'b0;
  logic [31:0] req_pc_i = '0;
  logic        req_allowin_o;
  logic        data_ok_i = 1'b0;
  logic [63:0] rdata_i = '0;
  logic        flush_i = 1'b0;
  logic        next_allowin_i = 1'b1;
  logic [1:0]  out_valid_o;
  logic [63:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        err_o;

  fetch_resp_queue #(
    .LANES(2), .INST_W(32), .PC_W(32), .DEPTH(4), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_fire_i(req_fire_i), .req_pc_i(req_pc_i), .req_allowin_o(req_allowin_o),
    .data_ok_i(data_ok_i), .rdata_i(rdata_i), .flush_i(flush_i),
    .next_allowin_i(next_allowin_i), .out_valid_o(out_valid_o),
    .out_inst_o(out_inst_o), .out_pc_o(out_pc_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [63:0] data; logic [1:0] mask; } exp_t;
  typedef struct { logic [31:0] pc; logic [63:0] data; logic [1:0] mask; logic [31:0] base; } vec_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  int          m_disc = 0;
  bit          m_err = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic [31:0] pc, input logic [63:0] dat);
    exp_t e;
    e.pc   = pc & 32'hFFFF_FFF8;
    e.mask = pc[2] ? 2'b10 : 2'b11;
    e.data = dat;
    return e;
  endfunction

  // One clock: drive inputs, check at negedge, update model, advance past edge
  task automatic cyc(input bit f, input logic [31:0] pc, input bit d,
                     input logic [63:0] dat, input bit fl);
    bit          allow;
    int          outst;
    exp_t        e;
    logic [31:0] p;
    req_fire_i = f; req_pc_i = pc; data_ok_i = d; rdata_i = dat; flush_i = fl;
    @(negedge clk);
    allow = (pend_q.size() + exp_q.size() < 4) && (pend_q.size() + m_disc < 4);
    chk("allowin", req_allowin_o, 96'(allow));
    chk("err", err_o, 96'(m_err));
    if (exp_q.size() == 0) begin
      chk("idle_valid", out_valid_o, 96'(0));
    end else begin
      e = exp_q[0];
      chk("sb_valid", out_valid_o, 96'(e.mask));
      chk("sb_pc", out_pc_o, 96'(e.pc));
      chk("sb_inst", out_inst_o, 96'(e.data));
      if (next_allowin_i) void'(exp_q.pop_front());
    end
    outst = pend_q.size() + m_disc;
    if (fl) begin
      if (d && outst == 0) m_err = 1'b1;
      m_disc = outst - ((d && outst > 0) ? 1 : 0);
      pend_q.delete();
      exp_q.delete();
    end else if (d) begin
      if (m_disc > 0) m_disc--;
      else if (pend_q.size() > 0) begin
        p = pend_q.pop_front();
        exp_q.push_back(mk_exp(p, dat));
      end else m_err = 1'b1;
    end
    if (f) begin
      if (allow) pend_q.push_back(pc);
      else m_err = 1'b1;
    end
    @(posedge clk); #1;
    req_fire_i = 1'b0; data_ok_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b1; req_fire_i = 1'b0; data_ok_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    pend_q.delete(); exp_q.delete(); m_disc = 0; m_err = 1'b0;
  endtask

  initial begin
    tbl[0] = '{pc: 32'h0000_1000, data: 64'h1111_0001_2222_0001, mask: 2'b11, base: 32'h0000_1000};
    tbl[1] = '{pc: 32'h0000_1004, data: 64'h1111_0002_2222_0002, mask: 2'b10, base: 32'h0000_1000};
    tbl[2] = '{pc: 32'h0000_1008, data: 64'h1111_0003_2222_0003, mask: 2'b11, base: 32'h0000_1008};
    tbl[3] = '{pc: 32'h0000_100C, data: 64'h1111_0004_2222_0004, mask: 2'b10, base: 32'h0000_1008};
    tbl[4] = '{pc: 32'h8000_0010, data: 64'hDEAD_BEEF_CAFE_F00D, mask: 2'b11, base: 32'h8000_0010};
    tbl[5] = '{pc: 32'hFFFF_FFFC, data: 64'h0123_4567_89AB_CDEF, mask: 2'b10, base: 32'hFFFF_FFF8};

    do_reset();
    chk("rst_valid", out_valid_o, 96'(0));
    chk("rst_err", err_o, 96'(0));
    chk("rst_allowin", req_allowin_o, 96'(1));
    next_allowin_i = 1'b1;

    foreach (tbl[i]) begin
      cyc(1, tbl[i].pc, 0, '0, 0);
      cyc(0, '0, 1, tbl[i].data, 0);
      chk("tbl_valid", out_valid_o, 96'(tbl[i].mask));
      chk("tbl_pc", out_pc_o, 96'(tbl[i].base));
      chk("tbl_inst", out_inst_o, 96'(tbl[i].data));
    end
    idle(2);

    // Back-to-back fetches, one cycle latency each
    cyc(1, 32'h1000, 0, '0, 0);
    cyc(1, 32'h1008, 0, '0, 0);
    cyc(0, '0, 1, 64'hAAAA_0000_BBBB_0000, 0);
    chk("b2b_valid0", out_valid_o, 96'(2'b11));
    chk("b2b_pc0", out_pc_o, 96'(32'h1000));
    cyc(0, '0, 1, 64'hAAAA_1111_BBBB_1111, 0);
    chk("b2b_pc1", out_pc_o, 96'(32'h1008));
    chk("b2b_inst1", out_inst_o, 96'(64'hAAAA_1111_BBBB_1111));
    idle(2);

    // Unaligned fetch: lane 1 carries the upper word
    cyc(1, 32'h1004, 0, '0, 0);
    cyc(0, '0, 1, 64'h5555_6666_7777_8888, 0);
    chk("odd_valid", out_valid_o, 96'(2'b10));
    chk("odd_lane1", out_inst_o[63:32], 96'(32'h5555_6666));
    idle(2);

    // Flush with three in flight: all three responses are discarded
    cyc(1, 32'h2000, 0, '0, 0);
    cyc(1, 32'h2004, 0, '0, 0);
    cyc(1, 32'h2008, 0, '0, 0);
    cyc(0, '0, 0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 1, 64'hBAD0_0000_0000_0000 + 64'(i), 0);
      chk("disc_valid", out_valid_o, 96'(0));
    end
    chk("disc_err", err_o, 96'(0));
    cyc(1, 32'h3000, 0, '0, 0);
    cyc(0, '0, 1, 64'h3000_0001_3000_0002, 0);
    chk("post_flush_pc", out_pc_o, 96'(32'h3000));
    idle(2);

    // Backpressure: fill the queue, then drain in order
    next_allowin_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 32'h4000 + 32'(4 * i), 0, '0, 0);
    chk("full_allowin_live", req_allowin_o, 96'(0));
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 64'h4444_0000_0000_0000 + 64'(i), 0);
    chk("full_allowin_q", req_allowin_o, 96'(0));
    chk("full_head_pc", out_pc_o, 96'(32'h4000));
    idle(2);
    next_allowin_i = 1'b1;
    idle(6);
    chk("drained_allowin", req_allowin_o, 96'(1));

    // Flush coincident with a response and a new request
    cyc(1, 32'h5000, 0, '0, 0);
    cyc(1, 32'h5008, 0, '0, 0);
    cyc(1, 32'h6000, 1, 64'h5000_5000_5000_5000, 1);
    cyc(0, '0, 1, 64'h5008_5008_5008_5008, 0);
    chk("coinc_drop", out_valid_o, 96'(0));
    cyc(0, '0, 1, 64'h6000_6000_6000_6000, 0);
    chk("coinc_pc", out_pc_o, 96'(32'h6000));
    chk("coinc_inst", out_inst_o, 96'(64'h6000_6000_6000_6000));
    idle(2);

    // Fire while blocked
    for (int i = 0; i < 4; i++) cyc(1, 32'h7000 + 32'(8 * i), 0, '0, 0);
    cyc(1, 32'h7100, 0, '0, 0);
    idle(2);
    chk("blocked_err", err_o, 96'(1));
    do_reset();
    chk("blocked_err_rst", err_o, 96'(0));

    // Orphan response, sticky until reset
    cyc(0, '0, 1, 64'h1, 0);
    idle(3);
    chk("orphan_err", err_o, 96'(1));
    do_reset();
    chk("orphan_err_rst", err_o, 96'(0));
    chk("orphan_allowin_rst", req_allowin_o, 96'(1));
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
